vga_pixel_pipe: RTL and testbench
=================================

Name: vga_pixel_pipe

Overview:
- Pixel fetch and colour output stage directly downstream of the display timing generator (1024 x 768, 65 MHz pixel clock).
- Consumes the generator's pixel_row, pixel_column, video_on, horiz_sync and vert_sync.
- Generates frame-buffer read addresses for a 256 x 192 bitmap scaled x4 to full screen, expands returned RGB332 data to 12-bit RGB444, and delays the syncs so colour and sync leave aligned at the VGA pins.
- Owns double-buffer selection, swapped only at vertical blanking under a req/ack handshake.

Parameters:
- MEM_LATENCY, 2: clocks from fb_addr change to matching fb_data valid (synchronous BRAM, 1..4 legal).
- VERT_PIXELS, 768: active rows; the swap/tick point is row VERT_PIXELS, column 0.
- BORDER_RGB, 12'h000: colour driven for active pixels outside the map. The map covers the full screen, so this applies only when pixel_column[10] or pixel_row >= 768.

Ports:
- clock  in  1  65 MHz pixel clock
- rst_n  in  1  synchronous active-low reset
- pixel_row  in  11  current row from timing generator
- pixel_column  in  11  current column from timing generator
- video_on_in  in  1  active-area flag from timing generator
- hsync_in  in  1  active-low horizontal sync from timing generator
- vsync_in  in  1  active-low vertical sync from timing generator
- swap_req  in  1  level request to swap display buffer
- fb_addr  out  17  {display_buf, pixel_row[9:2], pixel_column[9:2]}
- fb_data  in  8  RGB332 pixel, valid MEM_LATENCY clocks after fb_addr
- vga_rgb  out  12  {R[3:0],G[3:0],B[3:0]}
- vga_hsync  out  1  delayed active-low hsync
- vga_vsync  out  1  delayed active-low vsync
- swap_ack  out  1  one-clock pulse when a swap is taken
- frame_tick  out  1  one-clock pulse at start of vertical blanking
- display_buf  out  1  buffer currently scanned out

Behaviour:
- Reset (rst_n low at a clock edge) sets:
  - fb_addr = 0, vga_rgb = 0, vga_hsync = 1, vga_vsync = 1, swap_ack = 0, frame_tick = 0, display_buf = 0.
  - Every delay-pipeline stage to {hsync=1, vsync=1, video_on=0, in_map=0}.
- Reset mid-frame takes effect on the next edge. No stale colour is emitted after release, because the pipeline holds blank stages.
- Stage A (edge t): fb_addr is registered from the current inputs. Also registered, and carried with it: in_map = video_on_in && !pixel_column[10] && pixel_row < 768.
- fb_data for that address is valid at edge t+1+MEM_LATENCY and is registered into the colour stage at that edge.
- Total latency from inputs to vga_* is L = MEM_LATENCY + 2 clocks. hsync, vsync, video_on and in_map pass through an L-deep shift register, so all outputs for one pixel change on the same edge.
- Colour expansion, RGB332 {r2,r1,r0,g2,g1,g0,b1,b0}:
  - R = {r2,r1,r0,r2}
  - G = {g2,g1,g0,g2}
  - B = {b1,b0,b1,b0}
- Delayed video_on = 0 forces vga_rgb = 0. Delayed video_on = 1 with in_map = 0 gives vga_rgb = BORDER_RGB.
- Address wrap: scaling is pure truncation. Columns 4k..4k+3 share an address; rows likewise. No arithmetic carries.
- Swap point is a registered condition: pixel_row == VERT_PIXELS and pixel_column == 0.
  - frame_tick = 1 for exactly the following clock.
  - If swap_req = 1 at the swap point: display_buf toggles, and swap_ack = 1 for that same clock.
  - swap_req held high across several frames swaps once per frame. The requester must drop swap_req on swap_ack.
  - swap_req asserted on any other cycle is ignored until the next swap point.
- display_buf changes only inside vertical blanking, so fb_addr[16] never changes within the active area.
- Simultaneous reset and swap point: reset wins; no ack.

Test Plan:
- Reset: hold rst_n = 0 five clocks with arbitrary inputs -> vga_rgb = 0, vga_hsync = 1, vga_vsync = 1, display_buf = 0, swap_ack = 0. Release -> first L outputs remain blank.
- Latency/colour: MEM_LATENCY = 2, drive row = 8, col = 12, video_on = 1, model returns fb_data = 8'b111_000_11 -> fb_addr = {0,8'd2,8'd3} next clock; vga_rgb = 12'hF0F exactly 4 clocks after input.
- Scaling: sweep columns 0..7 on row 0 -> fb_addr[7:0] = 0,0,0,0,1,1,1,1. Rows 4..7 give fb_addr[15:8] = 1.
- Sync alignment: feed the full generator for one frame -> hsync falling edges at vga_hsync lag hsync_in by exactly L. vga_rgb = 0 whenever the delayed video_on = 0.
- Swap: swap_req = 1 from row 100 -> single swap_ack and frame_tick at the clock after row 768/col 0; display_buf 0 -> 1; fb_addr[16] = 1 from the next frame's row 0. With swap_req low next frame -> frame_tick only, no toggle.
- Reset mid-frame at row 300 with display_buf = 1 -> display_buf = 0, outputs blank, no spurious swap_ack.

Source files
------------

// File: rtl/vga_pixel_pipe_if.sv
// Frame-buffer read port and buffer-swap handshake between the pixel pipe and its neighbours.
// swap_req is a level held by the requester; swap_ack pulses for one clock when the swap is taken,
// and the requester must drop swap_req on seeing it.
interface vga_pixel_pipe_if;
  logic [16:0] fb_addr;
  logic [7:0]  fb_data;
  logic        swap_req;
  logic        swap_ack;

  modport master (output fb_addr, input fb_data, input swap_req, output swap_ack);
  modport slave  (input fb_addr, output fb_data, output swap_req, input swap_ack);
endinterface

// File: rtl/vga_pixel_pipe.sv
// Pixel fetch and colour stage: frame-buffer addressing for a x4-scaled 256x192 RGB332 bitmap,
// RGB332->RGB444 expansion, sync delay matching, and double-buffer selection at vertical blanking.
module vga_pixel_pipe #(
  parameter int          MEM_LATENCY = 2,
  parameter int          VERT_PIXELS = 768,
  parameter logic [11:0] BORDER_RGB  = 12'h000
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic [10:0]       pixel_row,
  input  logic [10:0]       pixel_column,
  input  logic              video_on_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  vga_pixel_pipe_if.master  fb,
  output logic [11:0]       vga_rgb,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic              frame_tick,
  output logic              display_buf
);

  localparam int          L      = MEM_LATENCY + 2;
  localparam logic [10:0] VP_ROW = 11'(VERT_PIXELS);

  typedef struct packed {
    logic hs;
    logic vs;
    logic von;
    logic in_map;
  } stage_t;

  localparam stage_t BLANK = '{hs: 1'b1, vs: 1'b1, von: 1'b0, in_map: 1'b0};

  stage_t      r_pipe [L];
  logic [16:0] r_fb_addr;
  logic [11:0] r_rgb;
  logic        r_buf;
  logic        r_tick;
  logic        r_ack;

  logic        w_in_map;
  logic        w_swap_pt;
  logic [7:0]  w_data;
  logic [11:0] w_rgb_exp;
  logic [11:0] w_rgb_next;
  stage_t      w_tail;
  logic        w_unused;

  assign w_in_map  = video_on_in && !pixel_column[10] && (pixel_row < VP_ROW);
  assign w_swap_pt = (pixel_row == VP_ROW) && (pixel_column == 11'd0);
  assign w_data    = fb.fb_data;
  assign w_rgb_exp = {w_data[7:5], w_data[7], w_data[4:2], w_data[4], w_data[1:0], w_data[1:0]};
  assign w_unused  = ^{pixel_row[1:0], pixel_column[1:0]};

  // The colour register loads on the same edge the flags move into the last stage,
  // so it looks one stage earlier to stay aligned with the syncs.
  assign w_tail = r_pipe[L-2];

  always_comb begin
    w_rgb_next = 12'h000;
    if (w_tail.von) begin
      w_rgb_next = w_tail.in_map ? w_rgb_exp : BORDER_RGB;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      for (int i = 0; i < L; i++) begin
        r_pipe[i] <= BLANK;
      end
      r_fb_addr <= 17'h0;
      r_rgb     <= 12'h000;
      r_buf     <= 1'b0;
      r_tick    <= 1'b0;
      r_ack     <= 1'b0;
    end else begin
      r_pipe[0] <= '{hs: hsync_in, vs: vsync_in, von: video_on_in, in_map: w_in_map};
      for (int i = 1; i < L; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
      r_fb_addr <= {r_buf, pixel_row[9:2], pixel_column[9:2]};
      r_rgb     <= w_rgb_next;
      r_tick    <= w_swap_pt;
      r_ack     <= w_swap_pt && fb.swap_req;
      // The swap point lies in vertical blanking, so the buffer never flips mid-picture.
      if (w_swap_pt && fb.swap_req) begin
        r_buf <= ~r_buf;
      end
    end
  end

  assign fb.fb_addr  = r_fb_addr;
  assign fb.swap_ack = r_ack;
  assign vga_rgb     = r_rgb;
  assign vga_hsync   = r_pipe[L-1].hs;
  assign vga_vsync   = r_pipe[L-1].vs;
  assign frame_tick  = r_tick;
  assign display_buf = r_buf;

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Bench for vga_pixel_pipe: drives abridged frames, models the BRAM, and scores outputs from queues.
module tb_vga_pixel_pipe;

  localparam int          ML     = 2;
  localparam int          L      = ML + 2;
  localparam int          VP     = 768;
  localparam logic [11:0] BORDER = 12'hA5C;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] pixel_row = '0;
  logic [10:0] pixel_column = '0;
  logic        video_on_in = 1'b0;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic [11:0] vga_rgb;
  logic        vga_hsync, vga_vsync, frame_tick, display_buf;

  vga_pixel_pipe_if fb_if();

  vga_pixel_pipe #(.MEM_LATENCY(ML), .VERT_PIXELS(VP), .BORDER_RGB(BORDER)) dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .pixel_row    (pixel_row),
    .pixel_column (pixel_column),
    .video_on_in  (video_on_in),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .fb           (fb_if),
    .vga_rgb      (vga_rgb),
    .vga_hsync    (vga_hsync),
    .vga_vsync    (vga_vsync),
    .frame_tick   (frame_tick),
    .display_buf  (display_buf)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [7:0] mem_fn(input logic [16:0] a);
    logic [7:0] m;
    if (a == 17'h00203) return 8'hE3;
    m = a[7:0] * 8'd37;
    return m ^ a[15:8] ^ {a[16], 7'h31} ^ 8'h1B;
  endfunction

  function automatic logic [11:0] expand(input logic [7:0] d);
    return {d[7], d[6], d[5], d[7], d[4], d[3], d[2], d[4], d[1], d[0], d[1], d[0]};
  endfunction

  // Synchronous BRAM model: data for an address appears ML clocks after the address.
  logic [7:0] mem_pipe [ML];
  always @(posedge clock) begin
    mem_pipe[0] <= mem_fn(fb_if.fb_addr);
    for (int i = 1; i < ML; i++) mem_pipe[i] <= mem_pipe[i-1];
  end
  assign fb_if.fb_data = mem_pipe[ML-1];

  int n_checks = 0;
  int n_pass   = 0;

  logic [45:0] exp_q[$];   // {due, rgb, hs, vs}
  logic [48:0] addr_q[$];  // {due, fb_addr}
  logic [34:0] ctrl_q[$];  // {due, frame_tick, swap_ack, display_buf}

  logic cur_rst = 1'b0;
  logic cur_req = 1'b0;
  logic m_buf   = 1'b0;

  initial fb_if.swap_req = 1'b0;

  task automatic drive_px(input logic [10:0] row, input logic [10:0] col,
                          input logic von, input logic hs, input logic vs);
    logic [11:0] rgb;
    logic        in_map;
    logic        swp;
    logic [16:0] a;
    logic [45:0] tmp;
    @(posedge clock); #1;
    rst_n = cur_rst; fb_if.swap_req = cur_req;
    pixel_row = row; pixel_column = col; video_on_in = von; hsync_in = hs; vsync_in = vs;
    if (!cur_rst) begin
      for (int i = 0; i < exp_q.size(); i++) begin
        if (int'(exp_q[i][45:14]) >= cyc + 1) begin
          tmp = exp_q[i]; tmp[13:0] = {12'h000, 1'b1, 1'b1}; exp_q[i] = tmp;
        end
      end
      exp_q.push_back({32'(cyc + L), 12'h000, 1'b1, 1'b1});
      addr_q.push_back({32'(cyc + 1), 17'h0});
      m_buf = 1'b0;
      ctrl_q.push_back({32'(cyc + 1), 1'b0, 1'b0, 1'b0});
    end else begin
      a      = {m_buf, row[9:2], col[9:2]};
      in_map = von && !col[10] && (row < 11'(VP));
      rgb    = !von ? 12'h000 : (!in_map ? BORDER : expand(mem_fn(a)));
      exp_q.push_back({32'(cyc + L), rgb, hs, vs});
      addr_q.push_back({32'(cyc + 1), a});
      swp = (row == 11'(VP)) && (col == 11'd0);
      if (swp && cur_req) m_buf = ~m_buf;
      ctrl_q.push_back({32'(cyc + 1), swp, swp && cur_req, m_buf});
    end
  endtask

  // One abridged scan line: a few active columns at both map edges, then blanking with hsync.
  task automatic drive_line(input logic [10:0] row);
    logic [10:0] col;
    logic        hs, von, vs;
    int          j;
    for (int k = 0; k < 36; k++) begin
      hs = 1'b1;
      if (k < 16) col = 11'(k);
      else if (k < 24) col = 11'(1000 + k);
      else begin
        j = k - 24; col = 11'(1024 + j * 8); hs = !(j >= 4 && j < 8);
      end
      von = (row < 11'(VP)) && (k < 24);
      vs  = !(row >= 11'd771 && row <= 11'd776);
      drive_px(row, col, von, hs, vs);
    end
  endtask

  logic [45:0] mon_e;
  logic [48:0] mon_a;
  logic [34:0] mon_c;
  always @(negedge clock) begin
    if (exp_q.size() > 0 && int'(exp_q[0][45:14]) <= cyc) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      if (int'(mon_e[45:14]) != cyc || {vga_rgb, vga_hsync, vga_vsync} !== mon_e[13:0])
        $display("FAIL sb_video cyc=%0d got rgb=%h hs=%b vs=%b exp rgb=%h hs=%b vs=%b",
                 cyc, vga_rgb, vga_hsync, vga_vsync, mon_e[13:2], mon_e[1], mon_e[0]);
      else n_pass++;
    end
    if (addr_q.size() > 0 && int'(addr_q[0][48:17]) <= cyc) begin
      mon_a = addr_q.pop_front();
      n_checks++;
      if (int'(mon_a[48:17]) != cyc || fb_if.fb_addr !== mon_a[16:0])
        $display("FAIL sb_addr cyc=%0d got=%h exp=%h", cyc, fb_if.fb_addr, mon_a[16:0]);
      else n_pass++;
    end
    if (ctrl_q.size() > 0 && int'(ctrl_q[0][34:3]) <= cyc) begin
      mon_c = ctrl_q.pop_front();
      n_checks++;
      if (int'(mon_c[34:3]) != cyc || {frame_tick, fb_if.swap_ack, display_buf} !== mon_c[2:0])
        $display("FAIL sb_ctrl cyc=%0d got tick/ack/buf=%b exp=%b", cyc,
                 {frame_tick, fb_if.swap_ack, display_buf}, mon_c[2:0]);
      else n_pass++;
    end
  end

  task automatic test_reset();
    cur_rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cur_req = 1'($urandom_range(0, 1));
      if (i == 2) drive_px(11'(VP), 11'd0, 1'b1, 1'b0, 1'b0);
      else drive_px(11'($urandom_range(0, 1343)), 11'($urandom_range(0, 1343)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    n_checks++; if (vga_rgb !== 12'h000) $display("FAIL reset_rgb got=%h exp=%h", vga_rgb, 12'h000); else n_pass++;
    n_checks++; if (vga_hsync !== 1'b1) $display("FAIL reset_hsync got=%b exp=1", vga_hsync); else n_pass++;
    n_checks++; if (vga_vsync !== 1'b1) $display("FAIL reset_vsync got=%b exp=1", vga_vsync); else n_pass++;
    n_checks++; if (display_buf !== 1'b0) $display("FAIL reset_buf got=%b exp=0", display_buf); else n_pass++;
    n_checks++; if (fb_if.swap_ack !== 1'b0) $display("FAIL reset_ack got=%b exp=0", fb_if.swap_ack); else n_pass++;
    n_checks++; if (fb_if.fb_addr !== 17'h0) $display("FAIL reset_addr got=%h exp=0", fb_if.fb_addr); else n_pass++;
    cur_rst = 1'b1; cur_req = 1'b0;
    drive_px(11'd40, 11'd40, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < L; i++) begin
      drive_px(11'd40, 11'(40 + i), 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (vga_rgb !== 12'h000 || vga_hsync !== 1'b1)
        $display("FAIL release_blank got rgb=%h hs=%b exp rgb=000 hs=1", vga_rgb, vga_hsync);
      else n_pass++;
    end
  endtask

  task automatic test_latency();
    drive_px(11'd8, 11'd12, 1'b1, 1'b1, 1'b1);
    drive_px(11'd800, 11'd1100, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (fb_if.fb_addr !== {1'b0, 8'd2, 8'd3}) $display("FAIL lat_addr got=%h exp=%h", fb_if.fb_addr, {1'b0, 8'd2, 8'd3});
    else n_pass++;
    for (int i = 2; i < L; i++) drive_px(11'd800, 11'd1100, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (vga_rgb === 12'hF0F) $display("FAIL lat_early got=%h exp=not F0F", vga_rgb); else n_pass++;
    drive_px(11'd800, 11'd1100, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (vga_rgb !== 12'hF0F) $display("FAIL lat_rgb got=%h exp=F0F", vga_rgb); else n_pass++;
  endtask

  task automatic test_scaling();
    for (int i = 0; i <= 8; i++) begin
      drive_px(11'd0, 11'(i), 1'b1, 1'b1, 1'b1);
      if (i > 0) begin
        n_checks++;
        if (fb_if.fb_addr[7:0] !== 8'((i - 1) >> 2))
          $display("FAIL scale_col col=%0d got=%h exp=%h", i - 1, fb_if.fb_addr[7:0], 8'((i - 1) >> 2));
        else n_pass++;
      end
    end
    for (int r = 4; r <= 8; r++) begin
      drive_px(11'(r), 11'd5, 1'b1, 1'b1, 1'b1);
      if (r > 4) begin
        n_checks++;
        if (fb_if.fb_addr[15:8] !== 8'd1) $display("FAIL scale_row row=%0d got=%h exp=01", r - 1, fb_if.fb_addr[15:8]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_border();
    drive_px(11'd10, 11'd1030, 1'b1, 1'b1, 1'b1);
    for (int i = 1; i < L; i++) drive_px(11'd770, 11'd5, 1'b1, 1'b1, 1'b1);
    drive_px(11'd767, 11'd1023, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (vga_rgb !== BORDER) $display("FAIL border_rgb got=%h exp=%h", vga_rgb, BORDER); else n_pass++;
    drive_px(11'd5, 11'd5, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_sync_lines();
    drive_line(11'd0);
    drive_line(11'd1);
    drive_line(11'd766);
    drive_line(11'd772);
    drive_line(11'd805);
  endtask

  task automatic test_swap();
    cur_req = 1'b0;
    drive_line(11'd99);
    cur_req = 1'b1;
    drive_line(11'd100);
    drive_line(11'd767);
    drive_px(11'(VP), 11'd0, 1'b0, 1'b1, 1'b1);
    drive_px(11'(VP), 11'd1, 1'b0, 1'b1, 1'b1);
    n_checks++; if (fb_if.swap_ack !== 1'b1) $display("FAIL swap_ack got=%b exp=1", fb_if.swap_ack); else n_pass++;
    n_checks++; if (frame_tick !== 1'b1) $display("FAIL swap_tick got=%b exp=1", frame_tick); else n_pass++;
    n_checks++; if (display_buf !== 1'b1) $display("FAIL swap_buf got=%b exp=1", display_buf); else n_pass++;
    cur_req = 1'b0;
    drive_px(11'(VP), 11'd2, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (fb_if.swap_ack !== 1'b0 || frame_tick !== 1'b0)
      $display("FAIL swap_pulse got ack=%b tick=%b exp 0 0", fb_if.swap_ack, frame_tick);
    else n_pass++;
    drive_line(11'd805);
    drive_px(11'd0, 11'd0, 1'b1, 1'b1, 1'b1);
    drive_px(11'd0, 11'd1, 1'b1, 1'b1, 1'b1);
    n_checks++; if (fb_if.fb_addr[16] !== 1'b1) $display("FAIL swap_addr16 got=%b exp=1", fb_if.fb_addr[16]); else n_pass++;
    cur_req = 1'b1;
    drive_px(11'd500, 11'd3, 1'b1, 1'b1, 1'b1);
    cur_req = 1'b0;
    drive_line(11'd500);
    drive_px(11'(VP), 11'd0, 1'b0, 1'b1, 1'b1);
    drive_px(11'(VP), 11'd1, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (frame_tick !== 1'b1 || fb_if.swap_ack !== 1'b0 || display_buf !== 1'b1)
      $display("FAIL noswap got tick/ack/buf=%b exp=101", {frame_tick, fb_if.swap_ack, display_buf});
    else n_pass++;
    cur_req = 1'b1;
    drive_px(11'(VP), 11'd0, 1'b0, 1'b1, 1'b1);
    drive_line(11'd0);
    drive_px(11'(VP), 11'd0, 1'b0, 1'b1, 1'b1);
    drive_px(11'(VP), 11'd1, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (fb_if.swap_ack !== 1'b1 || display_buf !== 1'b1)
      $display("FAIL swap_held got ack=%b buf=%b exp 1 1", fb_if.swap_ack, display_buf);
    else n_pass++;
    cur_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) drive_px(11'd300, 11'(i), 1'b1, 1'b1, 1'b1);
    cur_rst = 1'b0; cur_req = 1'b1;
    drive_px(11'd300, 11'd10, 1'b1, 1'b1, 1'b1);
    drive_px(11'(VP), 11'd0, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (display_buf !== 1'b0 || vga_rgb !== 12'h000)
      $display("FAIL midrst_state got buf=%b rgb=%h exp 0 000", display_buf, vga_rgb);
    else n_pass++;
    drive_px(11'd300, 11'd12, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (fb_if.swap_ack !== 1'b0 || frame_tick !== 1'b0)
      $display("FAIL midrst_ack got ack=%b tick=%b exp 0 0", fb_if.swap_ack, frame_tick);
    else n_pass++;
    drive_px(11'd300, 11'd13, 1'b1, 1'b1, 1'b1);
    cur_rst = 1'b1; cur_req = 1'b0;
    drive_line(11'd300);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_scaling();
    test_border();
    test_sync_lines();
    test_swap();
    test_reset_mid();
    for (int k = 0; k < L + 3; k++) @(negedge clock);
    #1;
    n_checks++; if (exp_q.size() != 0) $display("FAIL drain_video left=%0d exp=0", exp_q.size()); else n_pass++;
    n_checks++; if (addr_q.size() != 0) $display("FAIL drain_addr left=%0d exp=0", addr_q.size()); else n_pass++;
    n_checks++; if (ctrl_q.size() != 0) $display("FAIL drain_ctrl left=%0d exp=0", ctrl_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
